// File: rtl/axis_word_unpacker.sv
// Pops show-ahead FIFO words and emits them as a lane-ordered sample stream.
// Samples carry per-frame first/last markers; completed frames are counted.
module axis_word_unpacker #(
  parameter int unsigned WORD_BYTES  = 8,
  parameter int unsigned SAMPLE_BITS = 16,
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned FRAME_BITS  = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     u_fifo_rready,
  input  logic [8*WORD_BYTES-1:0]  u_fifo_rdata,
  output logic                     u_fifo_ren,
  output logic                     smp_valid,
  input  logic                     smp_ready,
  output logic [SAMPLE_BITS-1:0]   smp_data,
  output logic                     smp_first,
  output logic                     smp_last,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned LANES  = WORD_W / SAMPLE_BITS;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [FRAME_BITS-1:0] IDX_LAST  = FRAME_BITS'(FRAME_LEN - 1);

  // Elaboration-time parameter sanity
  if ((SAMPLE_BITS == 0) || (WORD_W % SAMPLE_BITS != 0) || (LANES < 1)) begin : g_bad_lanes
    $error("axis_word_unpacker: word width must be a whole multiple of SAMPLE_BITS");
  end
  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("axis_word_unpacker: FRAME_LEN must be at least 2");
  end
  if ((FRAME_BITS < 1) || (FRAME_BITS < $clog2(FRAME_LEN))) begin : g_bad_frame_bits
    $error("axis_word_unpacker: FRAME_BITS too narrow for FRAME_LEN");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                  state_q,     state_d;
  logic [WORD_W-1:0]       word_q,      word_d;
  logic [LANE_W-1:0]       lane_q,      lane_d;
  logic [FRAME_BITS-1:0]   samp_idx_q,  samp_idx_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;

  logic                    full;
  logic                    hs;
  logic                    last_lane;
  logic                    take;
  logic                    idx_last;
  logic [SAMPLE_BITS-1:0]  lane_sample;

  // Handshake and pop qualification; reset masks both so nothing moves while it is held
  always_comb begin
    full      = (state_q == ST_FULL);
    smp_valid = full & ~areset;
    hs        = smp_valid & smp_ready;
    last_lane = (lane_q == LANE_LAST);
    idx_last  = (samp_idx_q == IDX_LAST);
    take      = u_fifo_rready & ~areset & (~full | (hs & last_lane));
  end

  assign u_fifo_ren = take;

  // Lane select straight off the held word, no extra pipeline stage
  always_comb begin
    lane_sample = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_q == LANE_W'(k)) begin
        lane_sample = word_q[k*SAMPLE_BITS +: SAMPLE_BITS];
      end
    end
  end

  always_comb begin
    smp_data  = smp_valid ? lane_sample : '0;
    smp_first = smp_valid & (samp_idx_q == '0);
    smp_last  = smp_valid & idx_last;
    frame_cnt = frame_cnt_q;
  end

  // Next-state: word/lane sequencing and frame position tracking
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    samp_idx_d  = samp_idx_q;
    frame_cnt_d = frame_cnt_q;

    if (take) begin
      // A take on the last-lane handshake reloads without a bubble
      state_d = ST_FULL;
      word_d  = u_fifo_rdata;
      lane_d  = '0;
    end else if (full && hs) begin
      if (last_lane) begin
        state_d = ST_EMPTY;
        lane_d  = '0;
      end else begin
        lane_d  = lane_q + LANE_W'(1);
      end
    end

    if (hs) begin
      samp_idx_d = idx_last ? '0 : samp_idx_q + FRAME_BITS'(1);
      if (idx_last) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_EMPTY;
      word_q      <= '0;
      lane_q      <= '0;
      samp_idx_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      samp_idx_q  <= samp_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_word_unpacker.sv
// Directed bench for axis_word_unpacker with a small show-ahead FIFO model
// and FRAME_LEN=6 so frame boundaries fall mid-word.
module tb_axis_word_unpacker;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        u_fifo_rready = 1'b0;
  logic [63:0] u_fifo_rdata = '0;
  logic        u_fifo_ren;
  logic        smp_valid;
  logic        smp_ready = 1'b0;
  logic [15:0] smp_data;
  logic        smp_first;
  logic        smp_last;
  logic [15:0] frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] fifo_q[$];

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h000C_000B_000A_0009;

  axis_word_unpacker #(
    .WORD_BYTES (8),
    .SAMPLE_BITS(16),
    .FRAME_LEN  (6),
    .FRAME_BITS (3)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .u_fifo_rready(u_fifo_rready),
    .u_fifo_rdata (u_fifo_rdata),
    .u_fifo_ren   (u_fifo_ren),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_data     (smp_data),
    .smp_first    (smp_first),
    .smp_last     (smp_last),
    .frame_cnt    (frame_cnt)
  );

  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    u_fifo_rready = (fifo_q.size() > 0);
    u_fifo_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 64'h0;
  endtask

  task automatic push(input logic [63:0] w);
    fifo_q.push_back(w);
    drive_fifo();
    #1;
  endtask

  // One clock: pop the FIFO if the DUT strobed ren, apply new inputs, settle to negedge
  task automatic cyc(input logic rdy, input logic rst);
    logic pop;
    pop = u_fifo_ren;
    @(posedge aclk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    drive_fifo();
    smp_ready = rdy;
    areset    = rst;
    @(negedge aclk);
  endtask

  task automatic expect_s(input string tag, input logic v, input logic [15:0] d,
                          input logic f, input logic l, input logic ren);
    chk({tag, ".valid"}, 64'(smp_valid), 64'(v));
    chk({tag, ".data"},  64'(smp_data),  64'(d));
    chk({tag, ".first"}, 64'(smp_first), 64'(f));
    chk({tag, ".last"},  64'(smp_last),  64'(l));
    chk({tag, ".ren"},   64'(u_fifo_ren), 64'(ren));
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1);
    chk("rst_pulse.valid", 64'(smp_valid), 64'd0);
    cyc(1'b0, 1'b0);
    chk("rst_done.valid", 64'(smp_valid), 64'd0);
    chk("rst_done.fcnt", 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    // Reset held with data already waiting in the FIFO
    push(64'h1111);
    cyc(1'b0, 1'b1);
    expect_s("rst0", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst0.fcnt", 64'(frame_cnt), 64'd0);
    cyc(1'b0, 1'b1);
    expect_s("rst1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst1.fcnt", 64'(frame_cnt), 64'd0);
    cyc(1'b0, 1'b0);
    expect_s("rst_rel", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    expect_s("rst_take", 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Single word, lanes emitted LSB first then idle
    push(W1);
    chk("single.ren0", 64'(u_fifo_ren), 64'd1);
    cyc(1'b1, 1'b0); expect_s("single.l0", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("single.l1", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("single.l2", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("single.l3", 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("single.idle0", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("single.idle1", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Back-to-back words with frames of 6 crossing word boundaries
    push(W1);
    push(W2);
    push(W3);
    chk("b2b.ren0", 64'(u_fifo_ren), 64'd1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0);
      expect_s($sformatf("b2b.s%0d", i + 1), 1'b1, 16'(i + 1),
               (i == 0) || (i == 6), (i == 5) || (i == 11), (i == 3) || (i == 7));
      chk($sformatf("b2b.s%0d.fcnt", i + 1), 64'(frame_cnt), (i >= 6) ? 64'd1 : 64'd0);
    end
    cyc(1'b1, 1'b0);
    expect_s("b2b.idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("b2b.fcnt_end", 64'(frame_cnt), 64'd2);
    do_reset();

    // Backpressure on lane 2
    push(W1);
    cyc(1'b1, 1'b0); expect_s("bp.l0", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("bp.l1", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0);
      expect_s($sformatf("bp.hold%0d", i), 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0); expect_s("bp.rel", 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("bp.l3", 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("bp.idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Reset pulsed mid-word; next FIFO word restarts the frame
    push(W1);
    push(W2);
    cyc(1'b1, 1'b0); expect_s("mr.l0", 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("mr.l1", 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1); expect_s("mr.rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0); expect_s("mr.rel", 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("mr.rel.fcnt", 64'(frame_cnt), 64'd0);
    cyc(1'b1, 1'b0); expect_s("mr.w2l0", 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
    chk("mr.w2l0.fcnt", 64'(frame_cnt), 64'd0);
    cyc(1'b1, 1'b0); expect_s("mr.w2l1", 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("mr.w2l2", 1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("mr.w2l3", 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0); expect_s("mr.idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
